multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, SHALL set the width of the retired-instruction counter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 areset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 op  input  7  SHALL carry the opcode from the instruction register, Instr[6:0].
REQ-005 funct3  input  3 and funct7b5  input  1  SHALL carry Instr[14:12] and Instr[30].
REQ-006 Zero  input  1 and Sign  input  1  SHALL carry the ALU flags of the current cycle.
REQ-007 mem_ready  input  1  SHALL indicate that the shared instruction/data memory completes the current access this cycle.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  SHALL be the datapath strobes and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each, and ALUControl  output  3  SHALL be the datapath selects.
REQ-010 mem_req  output  1  SHALL request a memory access; halt  output  1  SHALL flag an illegal opcode; instret  output  CNT_W  SHALL count retired instructions.

Function
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL and ILLEGAL.
REQ-012 Transitions SHALL be: FETCH->DECODE on mem_ready; DECODE->MEMADR (lw, sw), EXECR (0110011), EXECI (0010011), BRANCH (1100011), JAL (1101111), otherwise ILLEGAL.
REQ-013 Further transitions SHALL be: MEMADR->MEMREAD (lw) or MEMWRITE (sw); MEMREAD->MEMWB on mem_ready; MEMWRITE->FETCH on mem_ready; MEMWB, ALUWB and BRANCH->FETCH; EXECR, EXECI and JAL->ALUWB; ILLEGAL->ILLEGAL.
REQ-014 In FETCH: AdrSrc=0, mem_req=1, ALUSrcA=00 (PC), ALUSrcB=10 (+4), ALUControl=ADD and ResultSrc=10; IRWrite=1 and PCWrite=1 only in the mem_ready cycle.
REQ-015 In DECODE: ALUSrcA=01 (OldPC), ALUSrcB=01 (imm), ALUControl=ADD, computing the branch/jump target.
REQ-016 In MEMADR: ALUSrcA=10 (RD1), ALUSrcB=01 and ALUControl=ADD.
REQ-017 In MEMREAD and MEMWRITE: AdrSrc=1, ResultSrc=00 and mem_req=1; MemWrite=1 only in MEMWRITE.
REQ-018 In MEMWB: ResultSrc=01 and RegWrite=1.
REQ-019 In ALUWB: ResultSrc=00 and RegWrite=1.
REQ-020 In EXECR: ALUSrcA=10 and ALUSrcB=00; in EXECI: ALUSrcA=10 and ALUSrcB=01.
REQ-021 In JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00 and PCWrite=1.
REQ-022 In BRANCH: ALUSrcA=10, ALUSrcB=00 and ALUControl=SUB; PCWrite SHALL be asserted when the branch is taken, with ResultSrc=00.
REQ-023 A branch SHALL be taken when: funct3 000 and Zero; 001 and !Zero; 100 and Sign; 101 and !Sign; any other funct3 is not taken.
REQ-024 ImmSrc SHALL be decoded from op in every state: I=00 (lw, I-ALU), S=01 (sw), B=10 (branch), J=11 (jal), otherwise 00.
REQ-025 ALU encodings SHALL be ADD 000, SUB 001, AND 010, OR 011, XOR 100, SLT 101, SLL 110, SRL 111.
REQ-026 In EXECR and EXECI, ALUControl SHALL be decoded from funct3; funct7b5=1 with funct3=000 SHALL select SUB only for R-type.
REQ-027 Outputs not listed for a state SHALL be 0.
REQ-028 mem_req SHALL stay high and all selects stable while waiting for mem_ready.
REQ-029 instret SHALL increment by 1, wrapping modulo 2^CNT_W, on exit from MEMWB, ALUWB, BRANCH and MEMWRITE.
REQ-030 In ILLEGAL: halt=1, every strobe is 0, instret is frozen.
REQ-031 Outputs SHALL be combinational from state, op, funct3, funct7b5, Zero, Sign and mem_ready; only state and instret are registered.

Reset
REQ-032 areset low SHALL force state to FETCH and instret to 0 immediately, regardless of clk; mid-access assertion abandons the access.
REQ-033 During reset: mem_req=1, halt=0 and all write strobes 0, with PCWrite and IRWrite gated off; operation resumes on the first clk edge after release.

Structure
REQ-034 A shared package SHALL hold the state encoding, opcode constants, ALU encodings and select encodings.
REQ-035 One sub-module, alu_decoder, SHALL map op, funct3, funct7b5 and an ALUOp class to ALUControl.

Verification
REQ-036 R-type add (op 0110011, funct3 000, funct7b5 0), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; RegWrite=1 in ALUWB; instret 0->1.
REQ-037 lw with mem_ready low for 3 cycles in MEMREAD -> mem_req held for 4 cycles, AdrSrc=1 throughout, then MEMWB with ResultSrc=01 and RegWrite=1.
REQ-038 bne (funct3 001) with Zero=1 -> PCWrite=0 in BRANCH; with Zero=0 -> PCWrite=1.
REQ-039 bge (funct3 101) with Sign=1 -> PCWrite=0 in BRANCH; with Sign=0 -> PCWrite=1.
REQ-040 op 1111111 -> ILLEGAL; halt=1 persists for 10 cycles; asserting areset returns to FETCH with halt=0.
REQ-041 CNT_W=4, 16 retirements -> instret wraps 15->0; areset asserted mid-MEMWRITE -> MemWrite drops asynchronously and instret=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operations and datapath select values.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  // ALUOp class handed from the FSM to the ALU decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:     return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                        input logic sign);
    case (funct3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return sign;
      3'b101:  return !sign;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the FSM's ALUOp class plus instruction fields to the ALU operation code.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // addi has no sub form, so bit 30 only selects SUB for register ops.
          3'b000:  alu_control_o = (op_i == OP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b010:  alu_control_o = ALU_SLT;
          3'b011:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          default: alu_control_o = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with a shared, handshaked memory and a retired
// instruction counter. Only state and instret are registered.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Sign,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             mem_req,
  output logic             halt,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  // Memory handshake: mem_req is held with every select stable until the
  // memory answers with mem_ready in the same cycle; that cycle completes it.

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  alu_op_t            alu_op;

  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BRANCH:    state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d   = S_FETCH;
          instret_d = instret_q + CNT_W'(1);
        end
      end
      S_MEMWB, S_ALUWB, S_BRANCH: begin
        state_d   = S_FETCH;
        instret_d = instret_q + CNT_W'(1);
      end
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    mem_req   = 1'b0;
    halt      = 1'b0;
    alu_op    = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        // Gating with areset keeps PC/IR untouched while reset is held.
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready & areset;
        PCWrite   = mem_ready & areset;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        mem_req = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        mem_req  = 1'b1;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_SUB;
        PCWrite = branch_taken(funct3, Zero, Sign);
      end
      S_ILLEGAL: halt = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .op_i          (op),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

  assign ImmSrc  = imm_src(op);
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: an instruction-level model plans the
// expected phase per cycle and a compare process checks all outputs each cycle.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             areset;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5, Zero, Sign, mem_ready;
  logic             PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]       ALUControl;
  logic             mem_req, halt;
  logic [CNT_W-1:0] instret;
  logic [3:0]       dbg_state;

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .areset(areset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .mem_req(mem_req), .halt(halt), .instret(instret),
    .state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_BRANCH, P_JAL, P_ILLEGAL
  } phase_e;

  typedef struct {
    phase_e ph;
    logic   mr;
  } step_t;

  step_t            plan_q[$];
  phase_e           exp_phase = P_FETCH;
  logic [CNT_W-1:0] exp_instret = '0;
  int               n_checks = 0;
  int               n_pass = 0;

  logic [2:0] alu_tab [8] = '{3'b000, 3'b110, 3'b101, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};

  logic       cap_pcw, cap_rw, cap_adr_all;
  logic [1:0] cap_rs;
  int         cap_mreq_cnt, cap_halt_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected outputs from the instruction phase and the current inputs.
  function automatic logic [17:0] model_out(phase_e ph, logic [6:0] o, logic [2:0] f3,
                                            logic f7, logic z, logic s, logic mr, logic rst_n);
    logic pcw, adr, mw, irw, rw, mreq, hlt;
    logic [1:0] rs, sa, sb, imm;
    logic [2:0] alu;
    {pcw, adr, mw, irw, rw, mreq, hlt} = '0;
    {rs, sa, sb, imm} = '0;
    alu = 3'b000;
    if (o == 7'b0100011) imm = 2'b01;
    else if (o == 7'b1100011) imm = 2'b10;
    else if (o == 7'b1101111) imm = 2'b11;
    case (ph)
      P_FETCH:    begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = mr & rst_n; pcw = mr & rst_n; end
      P_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      P_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      P_MEMREAD:  begin adr = 1; mreq = 1; end
      P_MEMWRITE: begin adr = 1; mreq = 1; mw = 1; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_ALUWB:    rw = 1;
      P_EXECR, P_EXECI: begin
        sa = 2'b10;
        sb = (ph == P_EXECI) ? 2'b01 : 2'b00;
        alu = alu_tab[f3];
        if (ph == P_EXECR && f3 == 3'b000 && f7) alu = 3'b001;
      end
      P_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      P_BRANCH: begin
        sa = 2'b10; alu = 3'b001;
        case (f3)
          3'b000: pcw = z;       // beq
          3'b001: pcw = !z;      // bne
          3'b100: pcw = s;       // blt
          3'b101: pcw = !s;      // bge
          default: pcw = 0;
        endcase
      end
      P_ILLEGAL:  hlt = 1;
      default: ;
    endcase
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, mreq, hlt};
  endfunction

  always @(negedge clk) begin
    chk($sformatf("outputs@%s st=%0d", exp_phase.name(), dbg_state),
        {14'b0, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
         ALUSrcB, ImmSrc, ALUControl, mem_req, halt},
        {14'b0, model_out(exp_phase, op, funct3, funct7b5, Zero, Sign, mem_ready, areset)});
    chk("instret", {28'b0, instret}, {28'b0, exp_instret});
  end

  task automatic do_reset();
    areset = 1'b0;
    mem_ready = 1'b1;
    exp_phase = P_FETCH;
    exp_instret = '0;
    #1;
    chk("reset_halt", {31'b0, halt}, 0);
    chk("reset_mem_req", {31'b0, mem_req}, 1);
    chk("reset_instret", {28'b0, instret}, 0);
    chk("reset_pcwrite_gated", {31'b0, PCWrite}, 0);
    chk("reset_irwrite_gated", {31'b0, IRWrite}, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    areset = 1'b1;
    mem_ready = 1'b0;
  endtask

  function automatic step_t st(phase_e p, logic m);
    step_t r;
    r.ph = p;
    r.mr = m;
    return r;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic s, input int fw, input int mw,
                           input int abort_at);
    bit retires = 1;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; Sign = s;
    cap_pcw = 1'bx; cap_rw = 1'b0; cap_rs = 2'bxx; cap_adr_all = 1'b1;
    cap_mreq_cnt = 0; cap_halt_cnt = 0;
    plan_q.delete();
    repeat (fw) plan_q.push_back(st(P_FETCH, 1'b0));
    plan_q.push_back(st(P_FETCH, 1'b1));
    plan_q.push_back(st(P_DECODE, rnd()));
    case (o)
      7'b0000011: begin
        plan_q.push_back(st(P_MEMADR, rnd()));
        repeat (mw) plan_q.push_back(st(P_MEMREAD, 1'b0));
        plan_q.push_back(st(P_MEMREAD, 1'b1));
        plan_q.push_back(st(P_MEMWB, rnd()));
      end
      7'b0100011: begin
        plan_q.push_back(st(P_MEMADR, rnd()));
        repeat (mw) plan_q.push_back(st(P_MEMWRITE, 1'b0));
        plan_q.push_back(st(P_MEMWRITE, 1'b1));
      end
      7'b0110011: begin plan_q.push_back(st(P_EXECR, rnd())); plan_q.push_back(st(P_ALUWB, rnd())); end
      7'b0010011: begin plan_q.push_back(st(P_EXECI, rnd())); plan_q.push_back(st(P_ALUWB, rnd())); end
      7'b1100011: plan_q.push_back(st(P_BRANCH, rnd()));
      7'b1101111: begin plan_q.push_back(st(P_JAL, rnd())); plan_q.push_back(st(P_ALUWB, rnd())); end
      default: begin
        retires = 0;
        repeat (10) plan_q.push_back(st(P_ILLEGAL, rnd()));
      end
    endcase
    foreach (plan_q[i]) begin
      exp_phase = plan_q[i].ph;
      mem_ready = plan_q[i].mr;
      @(negedge clk); #2;
      case (plan_q[i].ph)
        P_BRANCH:  cap_pcw = PCWrite;
        P_MEMREAD: begin if (mem_req) cap_mreq_cnt++; cap_adr_all &= AdrSrc; end
        P_MEMWB:   begin cap_rs = ResultSrc; cap_rw = RegWrite; end
        P_ALUWB:   cap_rw = RegWrite;
        P_ILLEGAL: if (halt) cap_halt_cnt++;
        default: ;
      endcase
      if (i == abort_at) begin
        chk("memwrite_before_abort", {31'b0, MemWrite}, 1);
        areset = 1'b0;
        exp_phase = P_FETCH;
        exp_instret = '0;
        #1;
        chk("memwrite_async_drop", {31'b0, MemWrite}, 0);
        chk("instret_async_clear", {28'b0, instret}, 0);
        chk("abort_mem_req", {31'b0, mem_req}, 1);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        areset = 1'b1;
        mem_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (retires) exp_instret++;
  endtask

  initial begin
    areset = 1'b1; op = '0; funct3 = '0; funct7b5 = 0; Zero = 0; Sign = 0; mem_ready = 0;
    #1;
    do_reset();

    run_instr(7'b0110011, 3'b000, 0, 0, 0, 2, 0, -1);          // add
    chk("add_aluwb_regwrite", {31'b0, cap_rw}, 1);
    chk("instret_after_add", {28'b0, instret}, 1);

    run_instr(7'b0000011, 3'b010, 0, 0, 0, 0, 3, -1);          // lw, 3 wait cycles
    chk("lw_mem_req_cycles", cap_mreq_cnt, 4);
    chk("lw_adrsrc_held", {31'b0, cap_adr_all}, 1);
    chk("lw_memwb_resultsrc", {30'b0, cap_rs}, 2'b01);
    chk("lw_memwb_regwrite", {31'b0, cap_rw}, 1);

    run_instr(7'b0100011, 3'b010, 0, 0, 0, 1, 1, -1);          // sw
    run_instr(7'b0010011, 3'b000, 0, 0, 0, 0, 0, -1);          // addi
    run_instr(7'b0110011, 3'b000, 1, 0, 0, 0, 0, -1);          // sub
    run_instr(7'b0010011, 3'b000, 1, 0, 0, 0, 0, -1);          // addi with bit30 set
    run_instr(7'b0110011, 3'b100, 0, 0, 0, 0, 0, -1);          // xor
    run_instr(7'b0010011, 3'b001, 0, 0, 0, 1, 0, -1);          // slli
    run_instr(7'b0110011, 3'b010, 0, 0, 0, 0, 0, -1);          // slt
    run_instr(7'b0010011, 3'b110, 0, 0, 0, 0, 0, -1);          // ori
    run_instr(7'b0110011, 3'b111, 0, 0, 0, 0, 0, -1);          // and
    run_instr(7'b0110011, 3'b101, 1, 0, 0, 0, 0, -1);          // sra -> SRL
    chk("instret_after_12", {28'b0, instret}, 12);

    run_instr(7'b1100011, 3'b001, 0, 1, 0, 0, 0, -1);          // bne, Zero=1
    chk("bne_zero1_not_taken", {31'b0, cap_pcw}, 0);
    run_instr(7'b1100011, 3'b001, 0, 0, 0, 0, 0, -1);          // bne, Zero=0
    chk("bne_zero0_taken", {31'b0, cap_pcw}, 1);
    run_instr(7'b1100011, 3'b101, 0, 0, 1, 0, 0, -1);          // bge, Sign=1
    chk("bge_sign1_not_taken", {31'b0, cap_pcw}, 0);
    chk("instret_at_15", {28'b0, instret}, 15);
    run_instr(7'b1100011, 3'b101, 0, 0, 0, 0, 0, -1);          // bge, Sign=0
    chk("bge_sign0_taken", {31'b0, cap_pcw}, 1);
    chk("instret_wraps_to_0", {28'b0, instret}, 0);

    run_instr(7'b1100011, 3'b000, 0, 1, 0, 0, 0, -1);          // beq taken
    run_instr(7'b1100011, 3'b100, 0, 1, 0, 0, 0, -1);          // blt not taken
    run_instr(7'b1100011, 3'b010, 0, 1, 1, 0, 0, -1);          // undefined funct3
    chk("branch_f3_010_not_taken", {31'b0, cap_pcw}, 0);
    run_instr(7'b1101111, 3'b000, 0, 0, 0, 0, 0, -1);          // jal
    chk("instret_after_jal", {28'b0, instret}, 4);

    run_instr(7'b0100011, 3'b010, 0, 0, 0, 0, 3, 3);           // sw aborted by reset
    run_instr(7'b0110011, 3'b000, 0, 0, 0, 0, 0, -1);          // add after abort
    chk("instret_after_abort_add", {28'b0, instret}, 1);

    run_instr(7'b1111111, 3'b000, 0, 0, 0, 0, 0, -1);          // illegal
    chk("illegal_halt_cycles", cap_halt_cnt, 10);
    chk("illegal_instret_frozen", {28'b0, instret}, 1);
    do_reset();
    run_instr(7'b0010011, 3'b100, 0, 0, 0, 1, 0, -1);          // xori after recovery
    chk("instret_after_recovery", {28'b0, instret}, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
